// File: rtl/regfile_bist_pkg.sv
// Shared types and data-pattern helpers for the register-file BIST sequencer.
package regfile_bist_pkg;

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  localparam logic [31:0] DEF_PATTERN = 32'hA5C30F96;

  // Base pattern (inverted on pass 1) with the address spread into every byte.
  function automatic logic [31:0] pat_word(input logic [4:0] a, input logic k,
                                           input logic [31:0] pattern);
    return (k ? ~pattern : pattern) ^ {4{3'b000, a}};
  endfunction

  function automatic logic [31:0] exp_word(input logic [4:0] a, input logic k,
                                           input logic check_zero,
                                           input logic [31:0] pattern);
    if (check_zero && a == 5'd0) return '0;
    return pat_word(a, k, pattern);
  endfunction

endpackage

// File: rtl/regfile_bist_pattern.sv
// Combinational data word for address a on pass k, optionally inverted.
module regfile_bist_pattern
  import regfile_bist_pkg::*;
#(
  parameter logic [31:0] PATTERN = DEF_PATTERN
) (
  input  logic [4:0]  a,
  input  logic        k,
  input  logic        inv,
  output logic [31:0] data
);

  assign data = pat_word(a, k, PATTERN) ^ {32{inv}};

endmodule

// File: rtl/regfile_bist.sv
// BIST initiator for a 32x32 2R1W register file: two write/read passes with
// inverted data, a decoy write during reads, and first-failure capture.
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter logic [31:0] PATTERN    = DEF_PATTERN,
  parameter bit          CHECK_ZERO = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic        Passed,
  output logic [4:0]  FailAddr,
  output logic        FailPort,
  output logic        FailPass,
  output logic [31:0] WriteData,
  output logic [4:0]  WriteRegister,
  output logic        RegWrite,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2
);

  state_t      state, state_n;
  logic [4:0]  a, a_n;
  logic        k, k_n;
  logic        last, accept, fail1, fail2, inv_n, busy_n;
  logic [31:0] wr_word, pat2, exp1, exp2;

  assign last   = (a == 5'd31);
  assign accept = (state == IDLE || state == DONE) && Start;

  // Port 2 walks the addresses in reverse, so its register is ~a.
  assign exp1  = exp_word(a, k, CHECK_ZERO, PATTERN);
  assign exp2  = (CHECK_ZERO && last) ? 32'h0 : pat2;
  assign fail1 = (state == RD) && (ReadData1 != exp1);
  assign fail2 = (state == RD) && (ReadData2 != exp2);

  always_comb begin
    state_n = state;
    a_n     = a;
    k_n     = k;
    unique case (state)
      IDLE, DONE: if (Start) begin
        state_n = WR;
        a_n     = 5'd0;
        k_n     = 1'b0;
      end
      WR: begin
        a_n = a + 5'd1;
        if (last) state_n = RD;
      end
      RD: begin
        a_n = a + 5'd1;
        if (fail1 || fail2) state_n = DONE;
        else if (last) begin
          state_n = k ? DONE : WR;
          k_n     = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy_n = (state_n == WR) || (state_n == RD);
  assign inv_n  = (state_n == RD);

  // Outputs are registered, so the write word is built from the next address.
  regfile_bist_pattern #(.PATTERN(PATTERN)) u_wr_pat (
    .a(a_n), .k(k_n), .inv(inv_n), .data(wr_word)
  );

  regfile_bist_pattern #(.PATTERN(PATTERN)) u_rd2_pat (
    .a(~a), .k(k), .inv(1'b0), .data(pat2)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state         <= IDLE;
      a             <= 5'd0;
      k             <= 1'b0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Passed        <= 1'b0;
      FailAddr      <= 5'd0;
      FailPort      <= 1'b0;
      FailPass      <= 1'b0;
      WriteData     <= 32'h0;
      WriteRegister <= 5'd0;
      RegWrite      <= 1'b0;
      ReadRegister1 <= 5'd0;
      ReadRegister2 <= 5'd0;
    end else begin
      state <= state_n;
      a     <= a_n;
      k     <= k_n;
      Busy  <= busy_n;
      Done  <= (state_n == DONE);

      // Port 1 takes priority when both ports miss on the same cycle.
      if (accept) begin
        Passed   <= 1'b0;
        FailAddr <= 5'd0;
        FailPort <= 1'b0;
        FailPass <= 1'b0;
      end else if (fail1) begin
        Passed   <= 1'b0;
        FailAddr <= a;
        FailPort <= 1'b0;
        FailPass <= k;
      end else if (fail2) begin
        Passed   <= 1'b0;
        FailAddr <= ~a;
        FailPort <= 1'b1;
        FailPass <= k;
      end else if (state == RD && last && k) begin
        Passed <= 1'b1;
      end

      // In RD the write port carries the inverted decoy with RegWrite low.
      RegWrite      <= (state_n == WR);
      WriteRegister <= busy_n ? a_n : 5'd0;
      WriteData     <= busy_n ? wr_word : 32'h0;
      ReadRegister1 <= inv_n ? a_n : 5'd0;
      ReadRegister2 <= inv_n ? ~a_n : 5'd0;
    end
  end

endmodule

// File: tb/tb_regfile_bist.sv
// Directed bench: behavioural register file with selectable faults around regfile_bist.
module tb_regfile_bist;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic        Busy, Done, Passed, FailPort, FailPass, RegWrite;
  logic [4:0]  FailAddr, WriteRegister, ReadRegister1, ReadRegister2;
  logic [31:0] WriteData, ReadData1, ReadData2;

  // 0 = good, 1 = reg 0 writable, 2 = RegWrite ignored, 3 = port 2 stuck on reg 17
  int          mode = 0;
  int          ncmp = 0;
  int          nerr = 0;
  logic [31:0] rf [32];

  regfile_bist dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Busy(Busy), .Done(Done),
    .Passed(Passed), .FailAddr(FailAddr), .FailPort(FailPort), .FailPass(FailPass),
    .WriteData(WriteData), .WriteRegister(WriteRegister), .RegWrite(RegWrite),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk)
    if ((RegWrite || mode == 2) && (WriteRegister != 5'd0 || mode == 1))
      rf[WriteRegister] <= WriteData;

  assign ReadData1 = (ReadRegister1 == 5'd0 && mode != 1) ? 32'h0 : rf[ReadRegister1];
  assign ReadData2 = (mode == 3) ? rf[17] :
                     (ReadRegister2 == 5'd0 && mode != 1) ? 32'h0 : rf[ReadRegister2];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"},   32'(Busy), 32'd0);
    chk({tag, ".done"},   32'(Done), 32'd0);
    chk({tag, ".passed"}, 32'(Passed), 32'd0);
    chk({tag, ".faddr"},  32'(FailAddr), 32'd0);
    chk({tag, ".fport"},  32'(FailPort), 32'd0);
    chk({tag, ".fpass"},  32'(FailPass), 32'd0);
    chk({tag, ".we"},     32'(RegWrite), 32'd0);
    chk({tag, ".wreg"},   32'(WriteRegister), 32'd0);
    chk({tag, ".wdata"},  WriteData, 32'd0);
    chk({tag, ".rr1"},    32'(ReadRegister1), 32'd0);
    chk({tag, ".rr2"},    32'(ReadRegister2), 32'd0);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    Start   = 1'b0;
    tick();
    tick();
    Reset_n = 1'b1;
  endtask

  // Called in cycle 1 of a run; returns in cycle 129.
  task automatic full_run(input string tag);
    for (int c = 1; c <= 128; c++) begin
      chk({tag, ".busy"}, 32'(Busy), 32'd1);
      chk({tag, ".done"}, 32'(Done), 32'd0);
      chk({tag, ".we"}, 32'(RegWrite), 32'((c <= 32) || (c >= 65 && c <= 96)));
      if (c == 1)  chk({tag, ".wd1"}, WriteData, 32'hA5C30F96);
      if (c == 3)  chk({tag, ".wd3"}, WriteData, 32'hA7C10D94);
      if (c == 18) chk({tag, ".wd18"}, WriteData, 32'hB4D21E87);
      if (c == 33) begin
        chk({tag, ".rr1_33"}, 32'(ReadRegister1), 32'd0);
        chk({tag, ".rr2_33"}, 32'(ReadRegister2), 32'd31);
        chk({tag, ".decoy33"}, WriteData, 32'h5A3CF069);
      end
      if (c == 65) chk({tag, ".wd65"}, WriteData, 32'h5A3CF069);
      tick();
    end
    chk({tag, ".done129"}, 32'(Done), 32'd1);
    chk({tag, ".pass129"}, 32'(Passed), 32'd1);
    chk({tag, ".busy129"}, 32'(Busy), 32'd0);
    chk({tag, ".we129"}, 32'(RegWrite), 32'd0);
  endtask

  task automatic launch();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic skip_to(input int from, input int to);
    for (int c = from; c < to; c++) tick();
  endtask

  task automatic chk_fail(input string tag, input logic [4:0] addr, input logic port);
    chk({tag, ".done"},   32'(Done), 32'd1);
    chk({tag, ".passed"}, 32'(Passed), 32'd0);
    chk({tag, ".busy"},   32'(Busy), 32'd0);
    chk({tag, ".faddr"},  32'(FailAddr), 32'(addr));
    chk({tag, ".fport"},  32'(FailPort), 32'(port));
    chk({tag, ".fpass"},  32'(FailPass), 32'd0);
  endtask

  initial begin
    // reset state
    mode = 0;
    Reset_n = 1'b0;
    tick();
    chk_zero("rst");
    do_reset();

    // 1: good register file, full run
    launch();
    full_run("t1");
    tick();
    chk("t1.hold_done", 32'(Done), 32'd1);

    // 2: register 0 writable
    do_reset();
    mode = 1;
    launch();
    skip_to(1, 33);
    chk("t2.rd1", ReadData1, 32'hA5C30F96);
    tick();
    chk_fail("t2", 5'd0, 1'b0);

    // 3: RegWrite ignored
    do_reset();
    mode = 2;
    launch();
    skip_to(1, 49);
    chk("t3.rr2", 32'(ReadRegister2), 32'd15);
    chk("t3.rd2", ReadData2, 32'h5533FF66);
    tick();
    chk_fail("t3", 5'd15, 1'b1);

    // 4: port 2 stuck on register 17
    do_reset();
    mode = 3;
    launch();
    skip_to(1, 33);
    chk("t4.rd2", ReadData2, 32'hB4D21E87);
    tick();
    chk_fail("t4", 5'd31, 1'b1);

    // 5: reset mid-run at cycle 40, then a clean run
    do_reset();
    mode = 0;
    launch();
    skip_to(1, 40);
    Reset_n = 1'b0;
    tick();
    chk_zero("t5.abort");
    Reset_n = 1'b1;
    launch();
    full_run("t5");

    // 6: Start held through the run, then restart from DONE
    do_reset();
    Start = 1'b1;
    tick();
    full_run("t6a");
    tick();
    chk("t6.done_clr", 32'(Done), 32'd0);
    chk("t6.pass_clr", 32'(Passed), 32'd0);
    Start = 1'b0;
    full_run("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
